// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared defaults, packed word type and counter-width helper for the bit packer
package turbo_pkg;

  localparam int N_DEF     = 8;
  localparam int WORD_DEF  = 4;
  localparam int DEPTH_DEF = 4;
  localparam int NBW       = $clog2(WORD_DEF + 1);

  // FIFO entry for the default word width; the top builds the same layout for its own WORD
  typedef struct packed {
    logic             last;
    logic [NBW-1:0]   nbits;
    logic [WORD_DEF-1:0] data;
  } packed_word_t;

  // width of a counter running 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turbo_bit_packer_if.sv
// rtl/turbo_bit_packer_if.sv - serial bit input and packed word ready/valid output bundle
interface turbo_bit_packer_if
  import turbo_pkg::*;
#(
  parameter int WORD = WORD_DEF
);
  localparam int NB = $clog2(WORD + 1);

  logic          in_valid;
  logic          single_x;
  logic          out_valid;
  logic          out_ready;
  logic [WORD-1:0] out_data;
  logic          out_last;
  logic [NB-1:0] out_nbits;

  // master drives the decoded bits and consumes words
  modport master (
    output in_valid, single_x, out_ready,
    input  out_valid, out_data, out_last, out_nbits
  );

  // slave is the packer itself
  modport slave (
    input  in_valid, single_x, out_ready,
    output out_valid, out_data, out_last, out_nbits
  );

endinterface

// File: rtl/turbo_bit_packer_fifo.sv
// rtl/turbo_bit_packer_fifo.sv - first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo_fwft
  import turbo_pkg::*;
#(
  parameter type T     = packed_word_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  output logic full,
  input  logic pop,
  output logic empty,
  output T     dout
);
  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // occupancy flags from the wrap bit; a push is legal when full only if a pop frees a slot
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  // storage and pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/turbo_bit_packer.sv
// rtl/turbo_bit_packer.sv - packs the serial decoded bit stream LSB-first into framed words
module turbo_bit_packer
  import turbo_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORD  = WORD_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  turbo_bit_packer_if.slave bus,
  output logic              overflow,
  output logic [15:0]       frames
);
  localparam int CW = cnt_w(WORD);
  localparam int BW = cnt_w(N);
  localparam int NB = $clog2(WORD + 1);

  typedef struct packed {
    logic            last;
    logic [NB-1:0]   nbits;
    logic [WORD-1:0] data;
  } word_t;

  logic [CW-1:0]   word_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [WORD-1:0] shift_reg;
  logic [WORD-1:0] data_next;
  logic            frame_end;
  logic            word_end;
  logic            pop;
  logic            full;
  logic            empty;
  logic            accept;
  logic            drop;
  word_t           din;
  word_t           dout;

  // current bit merged into the partial word, word/frame completion and push outcome
  always_comb begin
    data_next           = shift_reg;
    data_next[word_cnt] = bus.single_x;
    frame_end = bus.in_valid && (bit_cnt == BW'(N - 1));
    word_end  = bus.in_valid && ((word_cnt == CW'(WORD - 1)) || (bit_cnt == BW'(N - 1)));
    pop       = !empty && bus.out_ready;
    accept    = word_end && (!full || pop);
    drop      = word_end && full && !pop;
    din.last  = frame_end;
    din.nbits = NB'(word_cnt) + NB'(1);
    din.data  = data_next;
  end

  sync_fifo_fwft #(
    .T     (word_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (word_end),
    .din   (din),
    .full  (full),
    .pop   (pop),
    .empty (empty),
    .dout  (dout)
  );

  // head word is shown only while valid so an idle output reads as zero
  always_comb begin
    bus.out_valid = !empty;
    bus.out_data  = empty ? '0 : dout.data;
    bus.out_last  = empty ? 1'b0 : dout.last;
    bus.out_nbits = empty ? '0 : dout.nbits;
  end

  // position counters and shift register advance on every valid bit, even when a word is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (bus.in_valid) begin
      bit_cnt <= frame_end ? '0 : bit_cnt + BW'(1);
      if (word_end) begin
        word_cnt  <= '0;
        shift_reg <= '0;
      end else begin
        word_cnt  <= word_cnt + CW'(1);
        shift_reg <= data_next;
      end
    end
  end

  // sticky overrun flag and count of frames whose last word was stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      frames   <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (accept && frame_end) frames <= frames + 16'd1;
    end
  end

endmodule

// File: tb/tb_turbo_bit_packer.sv
// tb/tb_turbo_bit_packer.sv - randomized self-checking bench for turbo_bit_packer
module tb_turbo_bit_packer;

  localparam int NB_BITS = 8;

  typedef struct {
    int data;
    int nbits;
    int last;
  } wrd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ovf_a, ovf_b;
  logic [15:0] frm_a, frm_b;

  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_frames;
  bit   fbits [$];
  wrd_t exp_q [$];
  wrd_t got_q [$];

  turbo_bit_packer_if #(.WORD(4)) ifa ();
  turbo_bit_packer_if #(.WORD(3)) ifb ();

  turbo_bit_packer #(.N(8), .WORD(4), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .overflow(ovf_a), .frames(frm_a)
  );

  turbo_bit_packer #(.N(8), .WORD(3), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .overflow(ovf_b), .frames(frm_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // record every word handed over by either packer
  always @(negedge clk) begin
    wrd_t w;
    if (rst_n) begin
      if (ifa.out_valid && ifa.out_ready) begin
        w.data = int'(ifa.out_data); w.nbits = int'(ifa.out_nbits); w.last = int'(ifa.out_last);
        got_q.push_back(w);
      end
      if (ifb.out_valid && ifb.out_ready) begin
        w.data = int'(ifb.out_data); w.nbits = int'(ifb.out_nbits); w.last = int'(ifb.out_last);
        got_q.push_back(w);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // reference: split every complete frame of recorded bits into word-sized chunks, LSB first
  task automatic build_exp(input int w);
    wrd_t e;
    for (int f = 0; f < fbits.size() / NB_BITS; f++) begin
      for (int s = 0; s < NB_BITS; s += w) begin
        int len;
        len = (NB_BITS - s < w) ? NB_BITS - s : w;
        e.data = 0;
        for (int k = 0; k < len; k++) e.data |= int'(fbits[f*NB_BITS + s + k]) << k;
        e.nbits = len;
        e.last  = (s + len == NB_BITS) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic compare_words(input string t);
    int n;
    check({t, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", t, i),  got_q[i].data,  exp_q[i].data);
      check($sformatf("%s_nbits%0d", t, i), got_q[i].nbits, exp_q[i].nbits);
      check($sformatf("%s_last%0d", t, i),  got_q[i].last,  exp_q[i].last);
    end
    got_q.delete();
    exp_q.delete();
    fbits.delete();
  endtask

  task automatic drive(input bit sel_b, input bit v, input bit b);
    @(posedge clk);
    #1;
    if (sel_b) begin ifb.in_valid = v; ifb.single_x = b; end
    else       begin ifa.in_valid = v; ifa.single_x = b; end
  endtask

  task automatic send(input bit sel_b, input bit b, input int gap);
    repeat (gap) drive(sel_b, 1'b0, 1'b0);
    drive(sel_b, 1'b1, b);
    fbits.push_back(b);
  endtask

  task automatic settle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    rst_n = 1'b0;
    ifa.in_valid = 0; ifa.single_x = 0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.single_x = 0; ifb.out_ready = 1;
    exp_frames = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", ifa.out_valid, 0);
    check("rst_data",  ifa.out_data,  0);
    check("rst_last",  ifa.out_last,  0);
    check("rst_nbits", ifa.out_nbits, 0);
    check("rst_ovf",   ovf_a, 0);
    check("rst_frames", frm_a, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // fixed pattern, WORD=4, with a first-word latency probe
    for (int i = 0; i < 4; i++) send(0, pat[i], 0);
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_lat_valid", ifa.out_valid, 1);
    check("t1_lat_data",  ifa.out_data, 4'hD);
    for (int i = 4; i < 8; i++) send(0, pat[i], 0);
    settle(6);
    build_exp(4);
    compare_words("t1");
    exp_frames = 1;
    check("t1_frames", frm_a, exp_frames);

    // fixed pattern, WORD=3
    for (int i = 0; i < 8; i++) send(1, pat[i], 0);
    drive(1, 1'b0, 1'b0);
    settle(6);
    build_exp(3);
    compare_words("t2");
    check("t2_frames", frm_b, 1);
    check("t2_ovf", ovf_b, 0);

    // fill FIFO, then push and pop on the same edge while full
    ifa.out_ready = 0;
    for (int i = 0; i < 16; i++) send(0, 1'($urandom_range(0, 1)), 0);
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_full_valid", ifa.out_valid, 1);
    for (int i = 0; i < 3; i++) send(0, 1'($urandom_range(0, 1)), 0);
    @(posedge clk); #1;
    ifa.in_valid = 1; ifa.single_x = 1'($urandom_range(0, 1)); ifa.out_ready = 1;
    fbits.push_back(ifa.single_x);
    for (int i = 0; i < 4; i++) send(0, 1'($urandom_range(0, 1)), 0);
    settle(10);
    build_exp(4);
    compare_words("t5");
    exp_frames += 3;
    check("t5_ovf", ovf_a, 0);
    check("t5_frames", frm_a, exp_frames);

    // random gaps anywhere in three frames
    for (int i = 0; i < 3*NB_BITS; i++) send(0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    settle(8);
    build_exp(4);
    compare_words("t3");
    exp_frames += 3;
    check("t3_frames", frm_a, exp_frames);

    // overrun: three frames against a stalled consumer
    ifa.out_ready = 0;
    for (int i = 0; i < 3*NB_BITS; i++) send(0, 1'($urandom_range(0, 1)), 0);
    settle(3);
    build_exp(4);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    @(negedge clk);
    check("t4_ovf", ovf_a, 1);
    check("t4_frames", frm_a, exp_frames + 2);
    check("t4_hold_valid", ifa.out_valid, 1);
    check("t4_hold_data", ifa.out_data, exp_q[0].data);
    check("t4_hold_last", ifa.out_last, 0);
    @(posedge clk); #1; ifa.out_ready = 1;
    settle(8);
    compare_words("t4");
    exp_frames += 2;

    // reset in mid-frame
    for (int i = 0; i < 5; i++) send(0, 1'($urandom_range(0, 1)), 0);
    drive(0, 1'b0, 1'b0);
    rst_n = 1'b0;
    got_q.delete();
    fbits.delete();
    @(negedge clk);
    check("t6_rst_valid", ifa.out_valid, 0);
    check("t6_rst_data",  ifa.out_data, 0);
    check("t6_rst_ovf",   ovf_a, 0);
    check("t6_rst_frames", frm_a, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < NB_BITS; i++) send(0, 1'($urandom_range(0, 1)), 0);
    settle(6);
    build_exp(4);
    compare_words("t6");
    check("t6_frames", frm_a, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
